// File: rtl/dct_block_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// dct_pkg : block geometry, sample types and buffer states for the DCT block
//           scheduler.
// Rev 1.0
// ============================================================================
package dct_pkg;

    localparam int DCT_N  = 8;
    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] sample_t;
    typedef sample_t           row_t   [DCT_N];
    typedef sample_t           block_t [DCT_N][DCT_N];

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2
    } buf_state_t;

    function automatic int idx_width(input int bpm);
        return (bpm > 1) ? $clog2(bpm) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dct_block_scheduler_if.sv
`default_nettype none
// ============================================================================
// dct_block_scheduler_if : row input stream and block output bundle.
// Rev 1.0
// ============================================================================
interface dct_block_scheduler_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 2
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_row    [dct_pkg::DCT_N];
    logic                dct_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_block [dct_pkg::DCT_N][dct_pkg::DCT_N];
    logic [IDX_W-1:0]    out_block_idx;
    logic                out_mb_last;
    logic [15:0]         blocks_issued;
    logic                overflow_err;

    modport master (
        output in_valid, in_row, dct_ready,
        input  in_ready, out_valid, out_block, out_block_idx, out_mb_last,
               blocks_issued, overflow_err
    );

    modport slave (
        input  in_valid, in_row, dct_ready,
        output in_ready, out_valid, out_block, out_block_idx, out_mb_last,
               blocks_issued, overflow_err
    );
endinterface
`default_nettype wire

// File: rtl/dct_block_scheduler_buffer.sv
`default_nettype none
// ============================================================================
// dct_block_buffer : one 8x8 sample bank, row-wide write port, full-block read.
// Rev 1.0
// ============================================================================
module dct_block_buffer #(
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [2:0]        row_sel,
    input  wire logic [DATA_W-1:0] wr_row   [dct_pkg::DCT_N],
    output logic      [DATA_W-1:0] rd_block [dct_pkg::DCT_N][dct_pkg::DCT_N]
);

    // Contents are only read once all eight rows are rewritten, so no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            rd_block[row_sel] <= wr_row;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dct_block_scheduler.sv
`default_nettype none
// ============================================================================
// dct_block_scheduler : assembles 8x8 blocks into ping-pong buffers and issues
//                       each completed block to pre_dct as a one-cycle pulse.
// Rev 1.0
// ============================================================================
module dct_block_scheduler #(
    parameter int DATA_W        = 32,
    parameter int BLOCKS_PER_MB = 4,
    parameter int IDX_W         = dct_pkg::idx_width(BLOCKS_PER_MB)
) (
    input wire logic             clk,
    input wire logic             rst,
    dct_block_scheduler_if.slave bus
);
    import dct_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCKS_PER_MB - 1);

    buf_state_t        state      [2];
    buf_state_t        state_next [2];
    logic              wr_buf;
    logic              rd_buf;
    logic [2:0]        row_cnt;
    logic [IDX_W-1:0]  blk_cnt;
    logic [DATA_W-1:0] blk_data [2][DCT_N][DCT_N];
    logic              accept;
    logic              issue;
    logic              row_last;

    assign bus.in_ready = (state[wr_buf] != BUF_FULL);
    assign accept       = bus.in_valid && bus.in_ready;
    assign issue        = (state[rd_buf] == BUF_FULL) && bus.dct_ready;
    assign row_last     = (row_cnt == 3'd7);

    generate
        for (genvar b = 0; b < 2; b++) begin : g_buf
            dct_block_buffer #(.DATA_W(DATA_W)) u_buf (
                .clk      (clk),
                .we       (accept && (wr_buf == 1'(b))),
                .row_sel  (row_cnt),
                .wr_row   (bus.in_row),
                .rd_block (blk_data[b])
            );
        end
    endgenerate

    // Issue and write never target the same buffer: one needs FULL, the other not FULL.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_next[b] = state[b];
            if (issue && (rd_buf == 1'(b))) begin
                state_next[b] = BUF_EMPTY;
            end
            if (accept && (wr_buf == 1'(b))) begin
                state_next[b] = row_last ? BUF_FULL : BUF_FILLING;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= '{BUF_EMPTY, BUF_EMPTY};
            wr_buf            <= 1'b0;
            rd_buf            <= 1'b0;
            row_cnt           <= 3'd0;
            blk_cnt           <= '0;
            bus.out_valid     <= 1'b0;
            bus.out_block     <= '{default: '0};
            bus.out_block_idx <= '0;
            bus.out_mb_last   <= 1'b0;
            bus.blocks_issued <= 16'd0;
            bus.overflow_err  <= 1'b0;
        end else begin
            state         <= state_next;
            bus.out_valid <= issue;
            if (accept) begin
                row_cnt <= row_cnt + 3'd1;
                if (row_last) begin
                    wr_buf <= ~wr_buf;
                end
            end
            if (issue) begin
                bus.out_block     <= blk_data[rd_buf];
                bus.out_block_idx <= blk_cnt;
                bus.out_mb_last   <= (blk_cnt == LAST_IDX);
                blk_cnt           <= (blk_cnt == LAST_IDX) ? '0 : blk_cnt + 1'b1;
                bus.blocks_issued <= bus.blocks_issued + 16'd1;
                rd_buf            <= ~rd_buf;
            end
            if (bus.in_valid && !bus.in_ready) begin
                bus.overflow_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dct_block_scheduler.sv
`default_nettype none
// ============================================================================
// tb_dct_block_scheduler : directed table, corner sequences and random traffic
//                          against a sample-stream reference model.
// Rev 1.0
// ============================================================================
module tb_dct_block_scheduler;

    localparam int DW  = 32;
    localparam int BPM = 4;
    localparam int IW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dct_block_scheduler_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

    dct_block_scheduler #(.DATA_W(DW), .BLOCKS_PER_MB(BPM), .IDX_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference: every accepted sample since reset, in order; block k is samples[64k .. 64k+63].
    logic [DW-1:0] samples[$];
    int  m_rows = 0;
    int  m_iss  = 0;
    int  m_last = -1;
    bit  m_ov   = 1'b0;
    bit  m_ovf  = 1'b0;
    bit  seen_ready;

    typedef struct {
        bit rst;
        bit v;
        bit dr;
        int base;
        bit exp_ready;
        bit exp_ov;
        int exp_issued;
    } vec_t;
    vec_t tbl [12];

    int pulse_at[$];
    int pulse_idx[$];
    int pulse_last[$];
    logic [DW-1:0] pulse_first[$];
    int accepted;
    int drops;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_sample(input int k, input int r, input int c);
        if (k < 0) return '0;
        return samples[k*64 + r*8 + c];
    endfunction

    task automatic check_outputs();
        int bad = 0;
        int br = 0, bc = 0;
        chk("out_valid", bus.out_valid, m_ov);
        chk("blocks_issued", bus.blocks_issued, m_iss & 16'hFFFF);
        chk("overflow_err", bus.overflow_err, m_ovf);
        chk("out_block_idx", bus.out_block_idx, (m_last < 0) ? 0 : m_last % BPM);
        chk("out_mb_last", bus.out_mb_last, (m_last >= 0) && (m_last % BPM == BPM - 1));
        vectors++;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (bus.out_block[r][c] !== exp_sample(m_last, r, c)) begin
                    if (bad == 0) begin br = r; bc = c; end
                    bad++;
                end
        if (bad != 0) begin
            miscompares++;
            $display("FAIL out_block[%0d][%0d]: got %0h, expected %0h (%0d bad)",
                     br, bc, bus.out_block[br][bc], exp_sample(m_last, br, bc), bad);
        end
    endtask

    // One clock: drive at negedge, check in_ready, step the model at the edge, check outputs.
    task automatic cycle(input bit r, input bit v, input bit dr, input logic [DW-1:0] base);
        bit exp_ready;
        bit iss;
        rst           = r;
        bus.in_valid  = v;
        bus.dct_ready = dr;
        for (int c = 0; c < 8; c++) bus.in_row[c] = base + DW'(c);
        #1;
        exp_ready  = ((m_rows / 8) - m_iss) < 2;
        seen_ready = bus.in_ready;
        if (!r) chk("in_ready", bus.in_ready, exp_ready);
        @(posedge clk);
        if (r) begin
            samples.delete();
            m_rows = 0; m_iss = 0; m_last = -1; m_ov = 1'b0; m_ovf = 1'b0;
        end else begin
            iss  = (((m_rows / 8) - m_iss) > 0) && dr;
            m_ov = iss;
            if (iss) begin
                m_last = m_iss;
                m_iss++;
            end
            if (v && exp_ready) begin
                for (int c = 0; c < 8; c++) samples.push_back(base + DW'(c));
                m_rows++;
            end else if (v) begin
                m_ovf = 1'b1;
            end
        end
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic record(input int at);
        if (bus.out_valid) begin
            pulse_at.push_back(at);
            pulse_idx.push_back(int'(bus.out_block_idx));
            pulse_last.push_back(int'(bus.out_mb_last));
            pulse_first.push_back(bus.out_block[0][0]);
        end
    endtask

    task automatic clear_pulses();
        pulse_at.delete(); pulse_idx.delete(); pulse_last.delete(); pulse_first.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.dct_ready = 1'b0;
        for (int c = 0; c < 8; c++) bus.in_row[c] = '0;
        @(negedge clk);

        // Single block: rows r*8+c, out_valid in the cycle nine after the first row.
        tbl[0] = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0};
        for (int r = 0; r < 8; r++) tbl[1+r] = '{1'b0, 1'b1, 1'b1, r*8, 1'b1, 1'b0, 0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1};
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].rst, tbl[i].v, tbl[i].dr, DW'(tbl[i].base));
            if (!tbl[i].rst) chk("tbl_in_ready", seen_ready, tbl[i].exp_ready);
            chk("tbl_out_valid", bus.out_valid, tbl[i].exp_ov);
            chk("tbl_blocks_issued", bus.blocks_issued, tbl[i].exp_issued);
        end
        chk("tbl_block_2_5", bus.out_block[2][5], 21);
        chk("tbl_block_7_7", bus.out_block[7][7], 63);
        chk("tbl_idx", bus.out_block_idx, 0);

        // Two back-to-back blocks: no stall, pulses 8 cycles apart.
        cycle(1'b1, 1'b0, 1'b1, '0);
        clear_pulses(); drops = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, i < 16, 1'b1, DW'(1000 + i*8));
            if (i < 16 && !seen_ready) drops++;
            record(i);
        end
        chk("b2b_ready_drops", drops, 0);
        chk("b2b_pulses", pulse_at.size(), 2);
        if (pulse_at.size() == 2) begin
            chk("b2b_spacing", pulse_at[1] - pulse_at[0], 8);
            chk("b2b_idx0", pulse_idx[0], 0);
            chk("b2b_idx1", pulse_idx[1], 1);
        end

        // Downstream stalled: both buffers fill, then drain in fill order.
        cycle(1'b1, 1'b0, 1'b0, '0);
        accepted = 0;
        for (int i = 0; i < 24; i++) begin
            cycle(1'b0, 1'b1, 1'b0, DW'(2000 + accepted*8));
            if (seen_ready) accepted++;
        end
        chk("stall_accepted", accepted, 16);
        chk("stall_overflow", bus.overflow_err, 1);
        clear_pulses();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 1'b1, '0);
            record(i);
        end
        chk("stall_pulses", pulse_at.size(), 2);
        if (pulse_at.size() == 2) begin
            chk("stall_first_block", pulse_first[0], 2000);
            chk("stall_second_block", pulse_first[1], 2064);
        end

        // Reset in the middle of the second block.
        cycle(1'b1, 1'b0, 1'b1, '0);
        for (int i = 0; i < 13; i++) cycle(1'b0, 1'b1, 1'b1, DW'(3000 + i*8));
        cycle(1'b1, 1'b1, 1'b1, DW'(3104));
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_block", bus.out_block[0][0], 0);
        chk("rst_in_ready", bus.in_ready, 1);
        clear_pulses();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, i < 8, 1'b1, DW'(4000 + i*8));
            record(i);
        end
        chk("rst_refill_pulses", pulse_at.size(), 1);
        if (pulse_at.size() == 1) begin
            chk("rst_refill_idx", pulse_idx[0], 0);
            chk("rst_refill_data", pulse_first[0], 4000);
        end

        // Row 7 of buffer 1 lands in the same cycle buffer 0 is issued.
        cycle(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 1'b0, DW'(5000 + i*8));
        cycle(1'b0, 1'b1, 1'b1, DW'(5000 + 15*8));
        chk("sim_issue", bus.out_valid, 1);
        cycle(1'b0, 1'b1, 1'b0, DW'(5000 + 16*8));
        chk("sim_buf0_ready", seen_ready, 1);
        for (int i = 17; i < 24; i++) cycle(1'b0, 1'b1, 1'b0, DW'(5000 + i*8));
        clear_pulses();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b1, '0);
            record(i);
        end
        chk("sim_drain_pulses", pulse_at.size(), 2);
        if (pulse_at.size() == 2) chk("sim_third_block", pulse_first[1], 5000 + 16*8);

        // Random traffic until nine blocks, checking macroblock tagging.
        cycle(1'b1, 1'b0, 1'b0, '0);
        clear_pulses();
        for (int i = 0; i < 600 && pulse_at.size() < 9; i++) begin
            cycle(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom);
            record(i);
        end
        chk("mb_pulses", pulse_at.size(), 9);
        for (int k = 0; k < pulse_at.size(); k++) begin
            chk("mb_idx", pulse_idx[k], k % BPM);
            chk("mb_last", pulse_last[k], (k % BPM) == BPM - 1);
        end

        // Long random run with occasional resets.
        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 4) != 0, $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
